// File: rtl/par_pkg.sv
// Shared types and constants for the parallel-output UART transmitter slice.
package par_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/par_fifo.sv
// Synchronous show-ahead byte FIFO; pointers carry an extra wrap bit for full/empty.
module par_fifo
    import par_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [UART_DATA_BITS-1:0] din,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      empty,
    output logic                      full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic                      wr_en;
    logic                      rd_en;

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rd_en = pop && !empty;
        // A write into a full FIFO is fine when the head leaves at the same edge.
        wr_en = push && (!full || rd_en);
        dout  = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/par_uart_tx.sv
// 8N1 UART transmitter fed from the core's parallel output strobe via a byte FIFO.
// Define PAR_UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module par_uart_tx
    import par_pkg::*;
#(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] par_output_port,
    input  logic       par_output_signal,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int            BW        = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_t               state;
    logic [BW-1:0]             baud_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      bit_end;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic                      fifo_push;
    logic [UART_DATA_BITS-1:0] fifo_dout;
`ifdef PAR_UART_TX_PARITY_EN
    logic                      parity_bit;
`endif

    par_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (par_output_port),
        .dout (fifo_dout),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    always_comb begin
        bit_end   = (baud_cnt == BAUD_LAST);
        // End of STOP with data waiting pops straight into the next START.
        fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
        fifo_push = par_output_signal && (!fifo_full || fifo_pop);
        tx_busy   = (state != IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
            overflow <= 1'b0;
`ifdef PAR_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (par_output_signal && !fifo_push) overflow <= 1'b1;

            if (fifo_pop) begin
                state    <= START;
                baud_cnt <= '0;
                bit_idx  <= '0;
                shreg    <= fifo_dout;
                uart_tx  <= 1'b0;
`ifdef PAR_UART_TX_PARITY_EN
                parity_bit <= ^fifo_dout;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        baud_cnt <= '0;
                        uart_tx  <= 1'b1;
                    end
                    START: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            state    <= DATA;
                            uart_tx  <= shreg[0];
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            bit_idx  <= bit_idx + 3'd1;
                            if (bit_idx == LAST_BIT) begin
`ifdef PAR_UART_TX_PARITY_EN
                                state   <= PARITY;
                                uart_tx <= parity_bit;
`else
                                state   <= STOP;
                                uart_tx <= 1'b1;
`endif
                            end else begin
                                shreg   <= {1'b0, shreg[UART_DATA_BITS-1:1]};
                                uart_tx <= shreg[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
`ifdef PAR_UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            state    <= STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                        uart_tx <= 1'b1;
                    end
                    default: begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        uart_tx  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_par_uart_tx.sv
// Self-checking bench for par_uart_tx against a cycle-indexed queue/frame model.
module tb_par_uart_tx;
    import par_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int MAXC    = 256;
`ifdef PAR_UART_TX_PARITY_EN
    localparam int FRAME_BITS = UART_DATA_BITS + 3;
`else
    localparam int FRAME_BITS = UART_DATA_BITS + 2;
`endif
    localparam int FL = FRAME_BITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] par_output_port = '0;
    logic       par_output_signal = 1'b0;
    logic       uart_tx;
    logic       tx_busy;
    logic       fifo_full;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic            stb      [MAXC];
    logic [7:0]      stb_data [MAXC];
    logic [MAXC-1:0] exp_tx, exp_busy, exp_full, exp_ovf;
    logic [MAXC-1:0] obs_tx, obs_busy, obs_full, obs_ovf;

    par_uart_tx #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .par_output_port  (par_output_port),
        .par_output_signal(par_output_signal),
        .uart_tx          (uart_tx),
        .tx_busy          (tx_busy),
        .fifo_full        (fifo_full),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    // Line level idx cycles into the frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        int j;
        j = idx / CLK_DIV;
        if (j == 0) return 1'b0;
        if (j <= UART_DATA_BITS) return b[j-1];
`ifdef PAR_UART_TX_PARITY_EN
        if (j == UART_DATA_BITS + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            stb[i]      = 1'b0;
            stb_data[i] = '0;
        end
    endtask

    // Sample c is taken just after clock edge c; strobes in stb[c] are seen at edge c.
    task automatic build_model(input int n);
        logic [7:0] q[$];
        logic [7:0] fb;
        int         fstart;
        int         free_at;
        logic       ovf;
        bit         pop;
        bit         push;
        fb = '0; fstart = 0; free_at = 0; ovf = 1'b0;
        exp_tx = '0; exp_busy = '0; exp_full = '0; exp_ovf = '0;
        for (int c = 0; c < n; c++) begin
            pop  = (c >= free_at) && (q.size() > 0);
            push = stb[c] && ((q.size() < DEPTH) || pop);
            if (pop) begin
                fb      = q.pop_front();
                fstart  = c;
                free_at = c + FL;
            end
            if (push) q.push_back(stb_data[c]);
            else if (stb[c]) ovf = 1'b1;
            exp_tx[c]   = (c < free_at) ? frame_bit(fb, c - fstart) : 1'b1;
            exp_busy[c] = (c < free_at) || (q.size() > 0);
            exp_full[c] = (q.size() == DEPTH);
            exp_ovf[c]  = ovf;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        par_output_signal = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run(input string name, input int n, input bit do_rst);
        build_model(n);
        if (do_rst) apply_reset();
        obs_tx = '0; obs_busy = '0; obs_full = '0; obs_ovf = '0;
        for (int c = 0; c < n; c++) begin
            par_output_signal = stb[c];
            par_output_port   = stb_data[c];
            @(posedge clk);
            #1;
            obs_tx[c]   = uart_tx;
            obs_busy[c] = tx_busy;
            obs_full[c] = fifo_full;
            obs_ovf[c]  = overflow;
        end
        par_output_signal = 1'b0;
        checks++;
        if (obs_tx !== exp_tx) begin
            errors++;
            $display("FAIL %s uart_tx got %h want %h", name, obs_tx, exp_tx);
        end
        checks++;
        if (obs_busy !== exp_busy) begin
            errors++;
            $display("FAIL %s tx_busy got %h want %h", name, obs_busy, exp_busy);
        end
        checks++;
        if (obs_full !== exp_full) begin
            errors++;
            $display("FAIL %s fifo_full got %h want %h", name, obs_full, exp_full);
        end
        checks++;
        if (obs_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s overflow got %h want %h", name, obs_ovf, exp_ovf);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        #12;
        rst_n = 1'b0;
        #1;
        check_bit("reset_uart_tx", uart_tx, 1'b1);
        check_bit("reset_tx_busy", tx_busy, 1'b0);
        check_bit("reset_fifo_full", fifo_full, 1'b0);
        check_bit("reset_overflow", overflow, 1'b0);
        #20;
        rst_n = 1'b1;
    endtask

    task automatic test_single_byte();
        clear_stim();
        stb[0] = 1'b1; stb_data[0] = 8'h55;
        run("single", FL + 20, 1'b1);
        check_bit("single_start_latency", obs_tx[1], 1'b0);
        check_bit("single_busy_last", obs_busy[FL], 1'b1);
        check_bit("single_busy_drop", obs_busy[FL+1], 1'b0);
    endtask

    task automatic test_back_to_back();
        int cnt;
        clear_stim();
        stb[0] = 1'b1; stb_data[0] = 8'h41;
        stb[1] = 1'b1; stb_data[1] = 8'h42;
        run("back_to_back", 2*FL + 10, 1'b1);
        check_bit("b2b_second_start", obs_tx[FL+1], 1'b0);
        cnt = 0;
        for (int i = 1; i < 2*FL + 10; i++) cnt += int'(obs_busy[i]);
        checks++;
        if (cnt != 2*FL) begin
            errors++;
            $display("FAIL b2b_busy_cycles got %0d want %0d", cnt, 2*FL);
        end
    endtask

    task automatic test_overflow();
        clear_stim();
        for (int i = 0; i < 6; i++) begin
            stb[i]      = 1'b1;
            stb_data[i] = 8'h10 + 8'(i);
        end
        run("overflow", 5*FL + 10, 1'b1);
        check_bit("ovf_full_before", obs_full[3], 1'b0);
        check_bit("ovf_full_after5", obs_full[4], 1'b1);
        check_bit("ovf_flag_before", obs_ovf[4], 1'b0);
        check_bit("ovf_flag_set", obs_ovf[5], 1'b1);
        check_bit("ovf_flag_sticky", obs_ovf[5*FL+9], 1'b1);
    endtask

    task automatic test_reset_midframe();
        int bit3_cyc;
        bit3_cyc = 1 + (1 + 3) * CLK_DIV + 1;
        apply_reset();
        par_output_signal = 1'b1;
        par_output_port   = 8'hA5;
        for (int c = 0; c <= bit3_cyc; c++) begin
            @(posedge clk);
            #1;
            par_output_signal = 1'b0;
        end
        check_bit("midframe_bit3", uart_tx, frame_bit(8'hA5, bit3_cyc - 1));
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("midframe_rst_uart_tx", uart_tx, 1'b1);
        check_bit("midframe_rst_tx_busy", tx_busy, 1'b0);
        check_bit("midframe_rst_fifo_full", fifo_full, 1'b0);
        check_bit("midframe_rst_overflow", overflow, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stim();
        stb[0] = 1'b1; stb_data[0] = 8'h3C;
        run("post_reset", FL + 10, 1'b0);
    endtask

    task automatic test_race();
        clear_stim();
        stb[0] = 1'b1;      stb_data[0] = 8'($urandom);
        stb[FL+1] = 1'b1;   stb_data[FL+1] = 8'($urandom);
        run("race", 2*FL + 10, 1'b1);
        check_bit("race_idle_cycle", obs_tx[FL+1], 1'b1);
        check_bit("race_start", obs_tx[FL+2], 1'b0);
        check_bit("race_busy_held", obs_busy[FL+1], 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clear_stim();
            for (int c = 0; c < 120; c++) begin
                if (r == 1) stb[c] = ($urandom_range(0, 15) == 0);
                else        stb[c] = ($urandom_range(0, 3) != 0);
                stb_data[c] = 8'($urandom);
            end
            run($sformatf("random%0d", r), MAXC, 1'b1);
        end
    endtask

`ifdef PAR_UART_TX_PARITY_EN
    task automatic test_parity();
        clear_stim();
        stb[0] = 1'b1; stb_data[0] = 8'h07;
        run("parity_07", FL + 10, 1'b1);
        check_bit("parity_07_bit", obs_tx[1 + 9*CLK_DIV], 1'b1);
        check_bit("parity_07_busy_drop", obs_busy[1 + 11*CLK_DIV], 1'b0);
        clear_stim();
        stb[0] = 1'b1; stb_data[0] = 8'h03;
        run("parity_03", FL + 10, 1'b1);
        check_bit("parity_03_bit", obs_tx[1 + 9*CLK_DIV], 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_race();
        test_random();
`ifdef PAR_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/par_uart_tx.md
# par_uart_tx

Serial transmitter that consumes the core's parallel output channel (`par_output_port` / `par_output_signal`) and drives it out as asynchronous 8N1 UART. Sits directly downstream of the core's memory-mapped output logic. Buffers bytes in a small FIFO so the core can emit bursts without stalling, and flags any byte lost to FIFO overflow.

## Interface
Parameters:
- `CLK_DIV`, default 104: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, default 16: byte FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `par_output_port` in 8: byte from the core, valid when `par_output_signal` is high.
- `par_output_signal` in 1: write strobe; each high cycle is one byte.
- `uart_tx` out 1: serial line, idle high.
- `tx_busy` out 1: high while the FIFO is non-empty or a frame is in flight.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `overflow` out 1: sticky; set when a strobed byte is dropped; cleared only by reset.

## Operation
- Push: strobe high and (FIFO not full, or a pop in the same cycle) → byte written at that edge.
- Strobe high with FIFO full and no pop → byte dropped, `overflow` set, FIFO unchanged.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
- IDLE: `uart_tx`=1. On any edge with FIFO non-empty: pop head into shift register, clear bit counter, go to START.
- START: `uart_tx`=0 for `CLK_DIV` cycles → DATA.
- DATA: 8 bits, LSB first, each for `CLK_DIV` cycles; 3-bit index wraps 7→done → STOP.
- STOP: `uart_tx`=1 for `CLK_DIV` cycles. At the end, if FIFO non-empty, pop and go straight to START with no idle cycle; otherwise go to IDLE.
- Baud counter: `$clog2(CLK_DIV)` bits, counts 0..`CLK_DIV`-1, reloads to 0 on every bit boundary.
- `uart_tx` is a registered output.
- `tx_busy` = (state ≠ IDLE) | FIFO non-empty.

## Timing
- Reset values: `uart_tx`=1, `tx_busy`=0, `fifo_full`=0, `overflow`=0; state IDLE, FIFO empty, counters 0.
- Latency: strobe sampled at edge k → FIFO write at k → pop and START at k+1 → `uart_tx` low from k+1.
- Frame length: 10·`CLK_DIV` cycles (11·`CLK_DIV` with parity). Consecutive queued bytes have zero gap.
- A pop and a push in the same cycle are both honoured; the count is unchanged.
- Reset asserted mid-frame: `uart_tx` goes high immediately (asynchronously), the frame is abandoned, and the FIFO is emptied.
- Strobe on consecutive cycles is legal; one byte is accepted per cycle.

## Configuration
- `PAR_UART_TX_PARITY_EN` defined: an even-parity bit (XOR of the 8 data bits) is sent in a PARITY state of `CLK_DIV` cycles between DATA and STOP. Frame = 11·`CLK_DIV`.
- Not defined: no PARITY state, and no parity logic is synthesised. Frame = 10·`CLK_DIV`.

## Structure
- Shared package `par_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Constant `UART_DATA_BITS` = 8.
- Sub-module `par_fifo`: synchronous FIFO, `FIFO_DEPTH`×8.
  - Ports: push, pop, din, dout (head, shows ahead), empty, full.
  - Read/write pointers carry one extra wrap bit.
- `par_uart_tx` contains the FSM, baud counter, shift register and overflow flag.

## Test plan
- **Single byte.** `CLK_DIV`=4, one strobe with 0x55 → `uart_tx` low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles. `tx_busy` drops at cycle 40 after the pop.
- **Back-to-back.** Strobes with 0x41 then 0x42 on consecutive cycles → the second start bit immediately follows the first stop bit. Total busy time is 80 cycles.
- **Overflow.** `FIFO_DEPTH`=4, `CLK_DIV`=4, six consecutive strobes with 0x10..0x15:
  - 0x10 is popped at the second edge; `fifo_full` is high after the fifth strobe.
  - 0x15 is dropped and `overflow`=1.
  - Line output is 0x10..0x14 in order.
- **Reset mid-frame.** Assert `rst_n`=0 during DATA bit 3 of 0xA5 → `uart_tx`=1 at once and all status outputs are 0. After release, a new strobe with 0x3C transmits a clean frame.
- **Parity.** With `PAR_UART_TX_PARITY_EN`, send 0x07 → parity bit = 1, frame = 44 cycles at `CLK_DIV`=4. Send 0x03 → parity bit = 0.
- **Idle/strobe race.** Strobe arrives in the last STOP cycle of a frame with the FIFO empty → the byte is written at that edge. FSM goes to IDLE, then to START one edge later, with no byte lost.
